// File: rtl/serial_link_if.sv
// serial_link_if
//   CPU-side register bus of the link-cable serial port (SB at 0xFF01,
//   SC at 0xFF02).
//   sb_we  : SB write strobe, one cycle
//   sc_we  : SC write strobe, one cycle
//   wdata  : write data shared by both strobes
//   sb     : SB readback
//   sc     : SC readback {start, 6'b111111, clk_sel}
//   master : CPU / bus decoder side
//   slave  : serial engine side
interface serial_link_if;
  logic       sb_we;
  logic       sc_we;
  logic [7:0] wdata;
  logic [7:0] sb;
  logic [7:0] sc;

  modport master (
    output sb_we,
    output sc_we,
    output wdata,
    input  sb,
    input  sc
  );

  modport slave (
    input  sb_we,
    input  sc_we,
    input  wdata,
    output sb,
    output sc
  );
endinterface

// File: rtl/serial_link.sv
// serial_link
//   Game Boy link-cable serial engine. Owns SB/SC and runs the 8-bit
//   full-duplex exchange: SB goes out MSB-first on serial_out while the
//   bits sampled from serial_in are shifted into SB. The serial clock is
//   generated internally (CLK_DIV cpu cycles per period) or taken from
//   the link partner through a synchronizer.
//
//   CLK_DIV        : cpu cycles per internal SCK period, even and >= 4
//   clk, rst       : cpu clock, synchronous active-high reset
//   bus            : register bus (serial_link_if.slave)
//   serial_in      : SIN pin, asynchronous
//   serial_clk_in  : SCK from partner, asynchronous
//   serial_out     : SO pin
//   serial_clk_out : internally generated SCK (idles high)
//   serial_clk_oe  : SCK output enable (SC bit 0)
//   serial_int     : one-cycle pulse when a transfer completes
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | no transfer; SB/SC writable, SO and SCK high
//   SHIFT_INT | transfer clocked by the internal divider
//   SHIFT_EXT | transfer clocked by synchronized partner SCK
module serial_link #(
  parameter int CLK_DIV = 512
) (
  input  logic          clk,
  input  logic          rst,
  serial_link_if.slave  bus,
  input  logic          serial_in,
  input  logic          serial_clk_in,
  output logic          serial_out,
  output logic          serial_clk_out,
  output logic          serial_clk_oe,
  output logic          serial_int
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] LAST    = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_INT = 2'd1,
    SHIFT_EXT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       sb_q;
  logic             start_q;
  logic             clk_sel;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div;

  logic sin_s1, sin_s2;
  logic sck_s1, sck_s2, sck_s3;

  logic sck_rise, sck_fall;
  logic shift_evt, fall_evt;
  logic sb_load;

  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;

  // Internal SCK rises when the divider steps onto CLK_DIV/2 and falls
  // when it wraps back to 0, so events are decoded from the value held
  // just before that step.
  assign shift_evt = ((state == SHIFT_INT) && (div == HALF_M1)) ||
                     ((state == SHIFT_EXT) && sck_rise);
  assign fall_evt  = ((state == SHIFT_INT) && (div == LAST)) ||
                     ((state == SHIFT_EXT) && sck_fall);

  // SB is only writable between transfers.
  assign sb_load = bus.sb_we && (state == IDLE);

  assign bus.sb        = sb_q;
  assign bus.sc        = {start_q, 6'b111111, clk_sel};
  assign serial_clk_oe = clk_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sb_q           <= 8'h00;
      start_q        <= 1'b0;
      clk_sel        <= 1'b0;
      bit_cnt        <= 3'd0;
      div            <= '0;
      serial_out     <= 1'b1;
      serial_clk_out <= 1'b1;
      serial_int     <= 1'b0;
      sin_s1         <= 1'b1;
      sin_s2         <= 1'b1;
      sck_s1         <= 1'b1;
      sck_s2         <= 1'b1;
      sck_s3         <= 1'b1;
    end else begin
      sin_s1     <= serial_in;
      sin_s2     <= sin_s1;
      sck_s1     <= serial_clk_in;
      sck_s2     <= sck_s1;
      sck_s3     <= sck_s2;
      serial_int <= 1'b0;

      if (bus.sc_we) begin
        clk_sel <= bus.wdata[0];
        div     <= '0;
        bit_cnt <= 3'd0;
        if (sb_load) begin
          sb_q <= bus.wdata;
        end
        if (bus.wdata[7]) begin
          // Start or restart. A same-cycle SB load is what gets sent.
          start_q        <= 1'b1;
          state          <= bus.wdata[0] ? SHIFT_INT : SHIFT_EXT;
          serial_clk_out <= ~bus.wdata[0];
          serial_out     <= sb_load ? bus.wdata[7] : sb_q[7];
        end else begin
          // Abort (or plain clk_sel update when idle): SB keeps whatever
          // has been shifted so far and no interrupt is raised.
          start_q        <= 1'b0;
          state          <= IDLE;
          serial_clk_out <= 1'b1;
          serial_out     <= 1'b1;
        end
      end else begin
        if (sb_load) begin
          sb_q <= bus.wdata;
        end

        if (state == SHIFT_INT) begin
          div <= (div == LAST) ? '0 : div + DIV_W'(1);
          if (div == HALF_M1) begin
            serial_clk_out <= 1'b1;
          end else if (div == LAST) begin
            serial_clk_out <= 1'b0;
          end
        end

        if (shift_evt) begin
          sb_q    <= {sb_q[6:0], sin_s2};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            serial_int     <= 1'b1;
            serial_out     <= 1'b1;
            serial_clk_out <= 1'b1;
            div            <= '0;
          end
        end else if (fall_evt) begin
          serial_out <= sb_q[7];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_link.sv
module tb_serial_link;
  localparam int DIV  = 512;
  localparam int HALF = DIV / 2;
  localparam int DONE = HALF + 7 * DIV;

  logic clk = 1'b0;
  logic rst;
  logic serial_in, serial_clk_in;
  logic serial_out, serial_clk_out, serial_clk_oe, serial_int;

  int errors = 0;
  int checks = 0;

  serial_link_if bus();

  serial_link #(.CLK_DIV(DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .serial_in      (serial_in),
    .serial_clk_in  (serial_clk_in),
    .serial_out     (serial_out),
    .serial_clk_out (serial_clk_out),
    .serial_clk_oe  (serial_clk_oe),
    .serial_int     (serial_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe lands on the second edge (E0); returns 1ns after E0.
  task automatic cpu_write(input logic wsb, input logic wsc, input logic [7:0] d);
    @(posedge clk); #1;
    bus.sb_we = wsb; bus.sc_we = wsc; bus.wdata = d;
    @(posedge clk); #1;
    bus.sb_we = 1'b0; bus.sc_we = 1'b0;
  endtask

  task automatic run_plain(input int cycles, output int ints);
    ints = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (serial_int === 1'b1) ints++;
    end
  endtask

  // Follows an internal transfer started at E0; n counts edges after E0.
  // SIN bit k is presented at the SCK falling point preceding sample k.
  task automatic run_int(input logic loopback, input logic [7:0] pat, input int poke_n,
                         input logic chain, output logic [7:0] so_bits, output int int_n,
                         output int int_cnt, output int sclk_err, output logic [7:0] sc_pre);
    logic exp_sck;
    int   j;
    so_bits = 8'h00; int_n = -1; int_cnt = 0; sclk_err = 0; sc_pre = 8'h00;
    for (int n = 0; n <= DONE + 10; n++) begin
      j = n / DIV;
      exp_sck = (n >= DONE) || ((n % DIV) >= HALF);
      if (serial_clk_out !== exp_sck) sclk_err++;
      if ((n % DIV == 0) && (j < 8)) so_bits[7-j] = serial_out;
      if (n == DONE - 1) sc_pre = bus.sc;
      if (serial_int === 1'b1) begin
        int_cnt++;
        if (int_n < 0) int_n = n;
      end
      bus.sb_we = (n == poke_n);
      bus.wdata = (n == poke_n) ? 8'h55 : 8'h00;
      if (loopback) serial_in = serial_out;
      else if ((n % DIV == 0) && (j < 8)) serial_in = pat[7-j];
      if (chain && serial_int === 1'b1) begin
        bus.sc_we = 1'b1; bus.wdata = 8'h81;
      end
      @(posedge clk); #1;
      bus.sb_we = 1'b0; bus.sc_we = 1'b0;
      if (chain && int_cnt > 0) break;
    end
  endtask

  // Partner clocking: 8 periods, 10 cycles low then 10 high.
  task automatic run_ext(input logic [7:0] pat, input int hold_k, output logic [7:0] so_bits,
                         output int int_delay, output int int_cnt,
                         output logic [7:0] sb_hold, output int hold_ints);
    so_bits = 8'h00; int_delay = -1; int_cnt = 0; sb_hold = 8'h00; hold_ints = -1;
    for (int k = 1; k <= 8; k++) begin
      for (int i = 1; i <= 10; i++) begin
        if (i == 1) begin serial_clk_in = 1'b0; serial_in = pat[8-k]; end
        @(posedge clk); #1;
        if (serial_int === 1'b1) int_cnt++;
        if (i == 10) so_bits[8-k] = serial_out;
      end
      for (int i = 1; i <= 10; i++) begin
        if (i == 1) serial_clk_in = 1'b1;
        @(posedge clk); #1;
        if (serial_int === 1'b1) begin
          int_cnt++;
          if (k == 8 && int_delay < 0) int_delay = i;
        end
      end
      if (k == hold_k) begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1;
          if (serial_int === 1'b1) int_cnt++;
        end
        sb_hold = bus.sb;
        hold_ints = int_cnt;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (serial_int === 1'b1) int_cnt++;
    end
  endtask

  initial begin
    logic [7:0] so, scp, r0, p0, p1, sbh, exp_sb;
    int in_n, in_c, serr, ints, dly, hints;
    logic b;

    rst = 1'b1; serial_in = 1'b1; serial_clk_in = 1'b1;
    bus.sb_we = 1'b0; bus.sc_we = 1'b0; bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sb", bus.sb, 8'h00);
    check("rst_sc", bus.sc, 8'h7E);
    check("rst_so", serial_out, 1'b1);
    check("rst_sck", serial_clk_out, 1'b1);
    check("rst_oe", serial_clk_oe, 1'b0);
    check("rst_int", serial_int, 1'b0);
    rst = 1'b0;

    // Loopback, internal clock
    cpu_write(1'b1, 1'b0, 8'hA5);
    check("sb_load", bus.sb, 8'hA5);
    cpu_write(1'b0, 1'b1, 8'h81);
    check("start_sc", bus.sc, 8'hFF);
    check("start_oe", serial_clk_oe, 1'b1);
    check("start_sck_low", serial_clk_out, 1'b0);
    run_int(1'b1, 8'h00, -1, 1'b0, so, in_n, in_c, serr, scp);
    check("loop_so", so, 8'hA5);
    check("loop_sb", bus.sb, 8'hA5);
    check("loop_int_at", in_n, DONE);
    check("loop_int_cnt", in_c, 1);
    check("loop_sck", serr, 0);
    check("loop_sc_pre", scp, 8'hFF);
    check("loop_sc_post", bus.sc, 8'h7F);
    check("loop_so_idle", serial_out, 1'b1);

    // No partner
    cpu_write(1'b1, 1'b0, 8'h3C);
    cpu_write(1'b0, 1'b1, 8'h81);
    run_int(1'b0, 8'hFF, -1, 1'b0, so, in_n, in_c, serr, scp);
    check("nop_sb", bus.sb, 8'hFF);
    check("nop_so", so, 8'h3C);
    check("nop_sck", serr, 0);

    // Random internal exchange, with an SB write attempted mid-transfer
    r0 = 8'($urandom); p0 = 8'($urandom);
    cpu_write(1'b1, 1'b0, r0);
    cpu_write(1'b0, 1'b1, 8'h81);
    run_int(1'b0, p0, 700, 1'b0, so, in_n, in_c, serr, scp);
    check("rnd_so", so, r0);
    check("rnd_sb", bus.sb, p0);
    check("rnd_int_at", in_n, DONE);

    // Simultaneous SB load and start
    p0 = 8'($urandom);
    cpu_write(1'b1, 1'b1, 8'h99);
    run_int(1'b0, p0, -1, 1'b0, so, in_n, in_c, serr, scp);
    check("coll_so", so, 8'h99);
    check("coll_sb", bus.sb, p0);

    // Restart mid-transfer: two samples taken, then 8 fresh ones
    r0 = 8'($urandom); p0 = 8'($urandom);
    cpu_write(1'b1, 1'b0, r0);
    serial_in = 1'b0;
    cpu_write(1'b0, 1'b1, 8'h81);
    run_plain(1000, ints);
    cpu_write(1'b0, 1'b1, 8'h81);
    run_int(1'b0, p0, -1, 1'b0, so, in_n, in_c, serr, scp);
    check("rstrt_so", so, {r0[5:0], 2'b00});
    check("rstrt_sb", bus.sb, p0);
    check("rstrt_int_at", in_n, DONE);
    check("rstrt_int_cnt", in_c + ints, 1);

    // Back-to-back: new start written while serial_int is high
    r0 = 8'($urandom); p0 = 8'($urandom); p1 = 8'($urandom);
    cpu_write(1'b1, 1'b0, r0);
    cpu_write(1'b0, 1'b1, 8'h81);
    run_int(1'b0, p0, -1, 1'b1, so, in_n, in_c, serr, scp);
    check("b2b_first_int", in_n, DONE);
    check("b2b_restarted_sc", bus.sc, 8'hFF);
    run_int(1'b0, p1, -1, 1'b0, so, in_n, in_c, serr, scp);
    check("b2b_so", so, p0);
    check("b2b_sb", bus.sb, p1);
    check("b2b_int_at", in_n, DONE);

    // Abort after three samples
    r0 = 8'($urandom); b = 1'($urandom);
    cpu_write(1'b1, 1'b0, r0);
    serial_in = b;
    cpu_write(1'b0, 1'b1, 8'h81);
    run_plain(1400, ints);
    cpu_write(1'b0, 1'b1, 8'h01);
    exp_sb = {r0[4:0], b, b, b};
    check("abort_sb", bus.sb, exp_sb);
    check("abort_sc", bus.sc, 8'h7F);
    run_plain(4000, hints);
    check("abort_no_int", ints + hints, 0);
    check("abort_sb_hold", bus.sb, exp_sb);
    check("abort_so", serial_out, 1'b1);
    check("abort_sck", serial_clk_out, 1'b1);
    cpu_write(1'b1, 1'b0, 8'h5A);
    check("abort_idle_load", bus.sb, 8'h5A);

    // Sync reset mid-transfer
    cpu_write(1'b1, 1'b0, 8'($urandom));
    cpu_write(1'b0, 1'b1, 8'h81);
    run_plain(1000, ints);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_sb", bus.sb, 8'h00);
    check("mrst_sc", bus.sc, 8'h7E);
    check("mrst_so", serial_out, 1'b1);
    check("mrst_sck", serial_clk_out, 1'b1);
    check("mrst_oe", serial_clk_oe, 1'b0);
    run_plain(4000, hints);
    check("mrst_no_int", ints + hints, 0);

    // External clock, spec pattern, held high after 4 bits
    serial_clk_in = 1'b1;
    cpu_write(1'b1, 1'b0, 8'h0F);
    cpu_write(1'b0, 1'b1, 8'h80);
    check("ext_sc", bus.sc, 8'hFE);
    check("ext_oe", serial_clk_oe, 1'b0);
    run_ext(8'hC3, 4, so, dly, in_c, sbh, hints);
    check("ext_hold_sb", sbh, 8'hFC);
    check("ext_hold_int", hints, 0);
    check("ext_sb", bus.sb, 8'hC3);
    check("ext_so", so, 8'h0F);
    check("ext_int_delay", dly, 3);
    check("ext_int_cnt", in_c, 1);
    check("ext_sc_done", bus.sc, 8'h7E);

    // External clock, random data
    r0 = 8'($urandom); p0 = 8'($urandom);
    cpu_write(1'b1, 1'b0, r0);
    cpu_write(1'b0, 1'b1, 8'h80);
    run_ext(p0, 0, so, dly, in_c, sbh, hints);
    check("extr_sb", bus.sb, p0);
    check("extr_so", so, r0);
    check("extr_int_cnt", in_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
